// File: rtl/result_stream_pkg.sv
// Shared configuration-register addresses and small elaboration helpers
// for the result streaming path.
package result_stream_pkg;

   // Configuration register map (word addresses on the cfg bus).
   localparam int CFG_RES_LEN = 12;

   // Width of a lane index; a single-lane packer still needs one bit.
   function automatic int lane_bits(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Output word FIFO: register-array storage, head word presented straight
// from the array so a word written at edge t is visible right after t.
module result_fifo #(
   parameter int WIDTH  = 129,
   parameter int AWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   output logic [WIDTH-1:0]  rd_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int DEPTH = 1 << AWIDTH;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AWIDTH:0]  wr_ptr_q;
   logic [AWIDTH:0]  rd_ptr_q;
   logic [AWIDTH:0]  wr_ptr_d;
   logic [AWIDTH:0]  rd_ptr_d;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en_i && !full_o;
   assign do_rd = rd_en_i && !empty_o;

   assign wr_ptr_d = do_wr ? wr_ptr_q + (AWIDTH+1)'(1) : wr_ptr_q;
   assign rd_ptr_d = do_rd ? rd_ptr_q + (AWIDTH+1)'(1) : rd_ptr_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; stale entries are masked by the empty flag.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AWIDTH-1:0]] <= wr_data_i;
      end
   end

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                      (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AWIDTH-1:0]];

endmodule

// File: rtl/result_stream.sv
// Packs RATIO compute-array result beats into one wide outbound word and
// streams a length-armed transfer through a small output FIFO.
module result_stream
   import result_stream_pkg::*;
#(
   parameter int CFG_DWIDTH    = 32,
   parameter int CFG_AWIDTH    = 5,
   parameter int GROUP_NB      = 4,
   parameter int IMG_WIDTH     = 16,
   parameter int STR_RES_WIDTH = 128,
   parameter int FIFO_AWIDTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CFG_DWIDTH-1:0]         cfg_data,
   input  logic [CFG_AWIDTH-1:0]         cfg_addr,
   input  logic                          cfg_valid,
   input  logic [GROUP_NB*IMG_WIDTH-1:0] result_bus,
   input  logic                          result_last,
   input  logic                          result_val,
   output logic                          result_rdy,
   output logic [STR_RES_WIDTH-1:0]      str_res_bus,
   output logic                          str_res_last,
   output logic                          str_res_val,
   input  logic                          str_res_rdy,
   output logic                          busy,
   output logic                          err_len
);

   localparam int BEAT_W = GROUP_NB * IMG_WIDTH;
   localparam int RATIO  = STR_RES_WIDTH / BEAT_W;
   localparam int LANE_W = lane_bits(RATIO);

   generate
      if (RATIO < 1 || RATIO * BEAT_W != STR_RES_WIDTH) begin : g_bad_ratio
         $error("result_stream: STR_RES_WIDTH must be a positive multiple of GROUP_NB*IMG_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [15:0]              len_q, len_d;
   logic [15:0]              count_q, count_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic [STR_RES_WIDTH-1:0] pack_q, pack_d;
   logic                     err_q, err_d;

   logic                     arm;
   logic                     accept;
   logic                     at_len_end;
   logic                     is_final;
   logic                     lane_full;
   logic                     push;
   logic                     pop;
   logic [STR_RES_WIDTH-1:0] word_next;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [STR_RES_WIDTH:0]   fifo_head;
   logic                     cfg_unused;

   assign cfg_unused = ^cfg_data[CFG_DWIDTH-1:16];

   assign arm        = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RES_LEN)) &&
                       (cfg_data[15:0] != 16'd0);
   assign result_rdy = (state_q == ST_ACTIVE) && !fifo_full;
   assign accept     = result_val && result_rdy;
   assign at_len_end = (count_q == len_q - 16'd1);
   assign is_final   = result_last || at_len_end;
   assign lane_full  = (lane_q == LANE_W'(RATIO - 1));
   assign push       = accept && (lane_full || is_final);
   assign pop        = str_res_val && str_res_rdy;

   // Current beat merged into its lane; lanes above it are still zero.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         assign word_next[gi*BEAT_W +: BEAT_W] =
            (lane_q == LANE_W'(gi)) ? result_bus : pack_q[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      lane_d  = lane_q;
      pack_d  = pack_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_ACTIVE;
               len_d   = cfg_data[15:0];
               count_d = '0;
               lane_d  = '0;
               pack_d  = '0;
               err_d   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            if (accept) begin
               count_d = count_q + 16'd1;
               if (push) begin
                  pack_d = '0;
                  lane_d = '0;
               end else begin
                  pack_d = word_next;
                  lane_d = lane_q + LANE_W'(1);
               end
               if (is_final) begin
                  state_d = ST_DRAIN;
                  // Early last, or reaching the length without last, is a mismatch.
                  err_d   = err_q | (result_last ^ at_len_end);
               end
            end
         end
         ST_DRAIN: begin
            if (pop && str_res_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         count_q <= '0;
         lane_q  <= '0;
         pack_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         lane_q  <= lane_d;
         pack_q  <= pack_d;
         err_q   <= err_d;
      end
   end

   result_fifo #(
      .WIDTH  (STR_RES_WIDTH + 1),
      .AWIDTH (FIFO_AWIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push),
      .wr_data_i ({is_final, word_next}),
      .rd_en_i   (pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign str_res_val  = !fifo_empty;
   assign str_res_bus  = fifo_head[STR_RES_WIDTH-1:0];
   assign str_res_last = fifo_head[STR_RES_WIDTH];
   assign busy         = (state_q != ST_IDLE);
   assign err_len      = err_q;

endmodule

// File: tb/tb_result_stream.sv
// Self-checking bench for result_stream: table vectors, hand sequences for
// backpressure/reset, and randomized transfers against a packing model.
module tb_result_stream;
   import result_stream_pkg::*;

   localparam int RATIO  = 2;
   localparam int BEAT_W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  cfg_data;
   logic [4:0]   cfg_addr;
   logic         cfg_valid;
   logic [63:0]  result_bus;
   logic         result_last;
   logic         result_val;
   logic         result_rdy;
   logic [127:0] str_res_bus;
   logic         str_res_last;
   logic         str_res_val;
   logic         str_res_rdy;
   logic         busy;
   logic         err_len;

   always #5 clk = ~clk;

   result_stream dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_data     (cfg_data),
      .cfg_addr     (cfg_addr),
      .cfg_valid    (cfg_valid),
      .result_bus   (result_bus),
      .result_last  (result_last),
      .result_val   (result_val),
      .result_rdy   (result_rdy),
      .str_res_bus  (str_res_bus),
      .str_res_last (str_res_last),
      .str_res_val  (str_res_val),
      .str_res_rdy  (str_res_rdy),
      .busy         (busy),
      .err_len      (err_len)
   );

   typedef struct {
      int           len;
      int           last_idx;
      int           exp_nwords;
      logic         exp_err;
      logic [127:0] exp_final;
   } vec_t;

   vec_t         vecs [7];
   logic [63:0]  tb_beat [0:63];
   logic         tb_last [0:63];
   logic [128:0] rx_q [$];
   logic [128:0] exp_q [$];
   logic         exp_err;
   int           rdy_pct = 100;
   int           chk_cnt = 0;
   int           pass_cnt = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Downstream sink: random ready, records every word taken at the next edge.
   initial begin
      str_res_rdy = 1'b0;
      forever begin
         @(negedge clk);
         str_res_rdy = ($urandom_range(0, 99) < rdy_pct);
         if (str_res_val && str_res_rdy) rx_q.push_back({str_res_last, str_res_bus});
      end
   end

   task automatic cfg_write(input int addr, input int data);
      @(negedge clk);
      cfg_addr  = 5'(addr);
      cfg_data  = 32'(data);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic send(input int from, input int upto, input int budget, input int val_pct,
                       output int next, output int cycles);
      int idx = from;
      int cyc = 0;
      while (idx < upto && cyc < budget) begin
         @(negedge clk);
         result_val  = ($urandom_range(0, 99) < val_pct);
         result_bus  = tb_beat[idx];
         result_last = tb_last[idx];
         if (result_val && result_rdy) idx++;
         cyc++;
      end
      @(negedge clk);
      result_val  = 1'b0;
      result_last = 1'b0;
      next   = idx;
      cycles = cyc;
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < 400) begin
         @(negedge clk);
         c++;
      end
      chk("idle_timeout", 256'(busy), 256'(0));
   endtask

   // Reference: the transfer ends on the first beat carrying last or the
   // len-th beat; beats are grouped RATIO per word, LSB lane first.
   task automatic build_expected(input int len, input int nsent);
      int f = -1;
      logic [128:0] word;
      exp_q.delete();
      for (int k = 0; k < nsent; k++)
         if (f < 0 && (tb_last[k] || k == len - 1)) f = k;
      exp_err = (f >= 0) && !(tb_last[f] && f == len - 1);
      for (int w = 0; w * RATIO <= f; w++) begin
         word = '0;
         for (int l = 0; l < RATIO; l++)
            if (w * RATIO + l <= f) word[l*BEAT_W +: BEAT_W] = tb_beat[w*RATIO + l];
         word[128] = ((w + 1) * RATIO > f);
         exp_q.push_back(word);
      end
   endtask

   task automatic compare_rx(input string tag);
      chk($sformatf("%s_nwords", tag), 256'(rx_q.size()), 256'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < rx_q.size()) chk($sformatf("%s_w%0d", tag, i), 256'(rx_q[i]), 256'(exp_q[i]));
      chk($sformatf("%s_err", tag), 256'(err_len), 256'(exp_err));
      $display("xfer %s words=%0d err_len=%0b", tag, rx_q.size(), err_len);
   endtask

   initial begin
      int nx, nx2, cyc, nsent, len, mode, j;
      rst = 1'b0; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;
      result_bus = '0; result_last = 1'b0; result_val = 1'b0;

      vecs[0] = '{4,  3, 2, 1'b0, 128'h4444444444444444_3333333333333333};
      vecs[1] = '{3,  2, 2, 1'b0, 128'h0000000000000000_3333333333333333};
      vecs[2] = '{5,  2, 2, 1'b1, 128'h0000000000000000_3333333333333333};
      vecs[3] = '{2,  1, 1, 1'b0, 128'h2222222222222222_1111111111111111};
      vecs[4] = '{1, -1, 1, 1'b1, 128'h0000000000000000_1111111111111111};
      vecs[5] = '{4, -1, 2, 1'b1, 128'h4444444444444444_3333333333333333};
      vecs[6] = '{6,  0, 1, 1'b1, 128'h0000000000000000_1111111111111111};

      repeat (3) @(negedge clk);
      chk("rst_rdy", 256'(result_rdy), 256'(0));
      chk("rst_val", 256'(str_res_val), 256'(0));
      chk("rst_last", 256'(str_res_last), 256'(0));
      chk("rst_bus", 256'(str_res_bus), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_err", 256'(err_len), 256'(0));
      rst = 1'b1;

      // Table vectors with beat k = 0x1111.. * (k+1).
      for (int i = 0; i < 7; i++) begin
         rdy_pct = 70;
         for (int k = 0; k < 64; k++) begin
            tb_beat[k] = 64'h1111111111111111 * 64'(k + 1);
            tb_last[k] = (k == vecs[i].last_idx);
         end
         nsent = (vecs[i].last_idx >= 0) ? vecs[i].last_idx + 1 : vecs[i].len;
         rx_q.delete();
         cfg_write(CFG_RES_LEN, vecs[i].len);
         chk($sformatf("v%0d_arm_busy", i), 256'(busy), 256'(1));
         chk($sformatf("v%0d_arm_err", i), 256'(err_len), 256'(0));
         send(0, nsent, 300, 80, nx, cyc);
         chk($sformatf("v%0d_sent", i), 256'(nx), 256'(nsent));
         chk($sformatf("v%0d_rdy_after_final", i), 256'(result_rdy), 256'(0));
         wait_idle();
         chk($sformatf("v%0d_nwords", i), 256'(rx_q.size()), 256'(vecs[i].exp_nwords));
         if (rx_q.size() > 0) begin
            chk($sformatf("v%0d_final", i), 256'(rx_q[rx_q.size()-1][127:0]), 256'(vecs[i].exp_final));
            chk($sformatf("v%0d_lastflag", i), 256'(rx_q[rx_q.size()-1][128]), 256'(1));
         end
         if (rx_q.size() > 1)
            chk($sformatf("v%0d_first_nolast", i), 256'(rx_q[0][128]), 256'(0));
         chk($sformatf("v%0d_err", i), 256'(err_len), 256'(vecs[i].exp_err));
         $display("xfer vec%0d len=%0d words=%0d err_len=%0b", i, vecs[i].len, rx_q.size(), err_len);
      end

      // Full throughput with an always-ready sink.
      rdy_pct = 100;
      for (int k = 0; k < 8; k++) begin
         tb_beat[k] = {$urandom, $urandom};
         tb_last[k] = (k == 7);
      end
      rx_q.delete();
      cfg_write(CFG_RES_LEN, 8);
      send(0, 8, 50, 100, nx, cyc);
      chk("thru_cycles", 256'(cyc), 256'(8));
      wait_idle();
      build_expected(8, 8);
      compare_rx("thru");

      // Backpressure: sink stalled, FIFO fills after 16 words.
      rdy_pct = 0;
      for (int k = 0; k < 40; k++) begin
         tb_beat[k] = {$urandom, $urandom};
         tb_last[k] = (k == 39);
      end
      rx_q.delete();
      cfg_write(CFG_RES_LEN, 40);
      send(0, 40, 60, 100, nx, cyc);
      chk("bp_accepted", 256'(nx), 256'(32));
      chk("bp_rdy_low", 256'(result_rdy), 256'(0));
      chk("bp_val_high", 256'(str_res_val), 256'(1));
      rdy_pct = 100;
      send(nx, 40, 200, 100, nx2, cyc);
      chk("bp_rest_sent", 256'(nx2), 256'(40));
      wait_idle();
      build_expected(40, 40);
      compare_rx("bp");

      // Reset in the middle of a transfer.
      for (int k = 0; k < 20; k++) begin
         tb_beat[k] = {$urandom, $urandom};
         tb_last[k] = (k == 19);
      end
      cfg_write(CFG_RES_LEN, 20);
      send(0, 10, 100, 100, nx, cyc);
      result_val = 1'b1; result_bus = tb_beat[10]; result_last = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_rdy", 256'(result_rdy), 256'(0));
      chk("mrst_val", 256'(str_res_val), 256'(0));
      chk("mrst_last", 256'(str_res_last), 256'(0));
      chk("mrst_bus", 256'(str_res_bus), 256'(0));
      chk("mrst_busy", 256'(busy), 256'(0));
      chk("mrst_err", 256'(err_len), 256'(0));
      rst = 1'b1; result_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("mrst_quiet", 256'(str_res_val), 256'(0));
      cfg_write(CFG_RES_LEN, 0);
      chk("len0_ignored", 256'(busy), 256'(0));
      rx_q.delete();
      tb_beat[0] = {$urandom, $urandom}; tb_last[0] = 1'b0;
      tb_beat[1] = {$urandom, $urandom}; tb_last[1] = 1'b1;
      cfg_write(CFG_RES_LEN, 2);
      cfg_write(CFG_RES_LEN, 7);
      chk("rearm_busy", 256'(busy), 256'(1));
      send(0, 2, 50, 100, nx, cyc);
      wait_idle();
      build_expected(2, 2);
      compare_rx("after_rst");

      // Randomized transfers against the model.
      for (int t = 0; t < 25; t++) begin
         rdy_pct = $urandom_range(30, 100);
         len  = $urandom_range(1, 12);
         mode = $urandom_range(0, 2);
         j    = $urandom_range(0, len - 1);
         for (int k = 0; k < 64; k++) begin
            tb_beat[k] = {$urandom, $urandom};
            tb_last[k] = 1'b0;
         end
         if (mode == 0) begin tb_last[len-1] = 1'b1; nsent = len; end
         else if (mode == 1) begin tb_last[j] = 1'b1; nsent = j + 1; end
         else nsent = len;
         rx_q.delete();
         cfg_write(CFG_RES_LEN, len);
         send(0, nsent, 300, $urandom_range(50, 100), nx, cyc);
         chk($sformatf("r%0d_sent", t), 256'(nx), 256'(nsent));
         wait_idle();
         build_expected(len, nsent);
         compare_rx($sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
